traffic_phase_arbiter: RTL and testbench

TRAFFIC_PHASE_ARBITER -- requirements
Module: traffic_phase_arbiter

---
 rtl/traffic_phase_arbiter_if.sv | 28 ++
 rtl/traffic_phase_arbiter.sv | 173 +++++++++++++++++
 tb/tb_traffic_phase_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_arbiter_if.sv
// Lamp/request bundle between a traffic controller and its approach-side driver.
// The master drives timebase and requests; the slave (arbiter) drives the lamps.
interface traffic_phase_arbiter_if;
    logic       tick;
    logic [2:0] req;
    logic [2:0] green;
    logic [2:0] yellow;
    logic [2:0] red;
    logic [1:0] active_id;

    modport master (
        output tick,
        output req,
        input  green,
        input  yellow,
        input  red,
        input  active_id
    );

    modport slave (
        input  tick,
        input  req,
        output green,
        output yellow,
        output red,
        output active_id
    );
endinterface

// File: rtl/traffic_phase_arbiter.sv
// Three-approach traffic phase arbiter: round-robin green grants with minimum/maximum
// green dwell, yellow and all-red clearance, all timed in ticks of an external timebase.
module traffic_phase_arbiter #(
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 10,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    traffic_phase_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned N_APP = 3;
    localparam int unsigned ID_W  = 2;

    localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] C_ALLRED_END = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] C_GMIN_END   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] C_GMAX_END   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] C_YEL_END    = CNT_W'(YELLOW_T - 1);
    localparam logic [ID_W-1:0]  C_ID_NONE    = ID_W'(3);
    localparam logic [ID_W-1:0]  C_LAST_RST   = ID_W'(2);

    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [ID_W-1:0]    r_last;
    logic [ID_W-1:0]    w_last_nxt;
    logic [ID_W-1:0]    r_srv;
    logic [ID_W-1:0]    w_srv_nxt;
    logic [ID_W-1:0]    w_grant;
    logic [N_APP-1:0]   w_srv_mask;
    logic [N_APP-1:0]   w_other;
    logic [N_APP-1:0]   w_nxt_mask;

    logic [N_APP-1:0]   r_green;
    logic [N_APP-1:0]   r_yellow;
    logic [N_APP-1:0]   r_red;
    logic [ID_W-1:0]    r_active_id;
    logic [N_APP-1:0]   w_green_nxt;
    logic [N_APP-1:0]   w_yellow_nxt;
    logic [N_APP-1:0]   w_red_nxt;
    logic [ID_W-1:0]    w_active_id_nxt;

    // Round-robin pick: first set request in order last+1, last+2, last (mod 3).
    function automatic logic [ID_W-1:0] f_grant(input logic [N_APP-1:0] req,
                                                input logic [ID_W-1:0]  last);
        logic [ID_W-1:0] o0;
        logic [ID_W-1:0] o1;
        logic [ID_W-1:0] o2;
        case (last)
            2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
        if (req[o0])      f_grant = o0;
        else if (req[o1]) f_grant = o1;
        else if (req[o2]) f_grant = o2;
        else              f_grant = o0;
    endfunction

    assign w_grant    = f_grant(bus.req, r_last);
    assign w_srv_mask = N_APP'(1) << r_srv;
    assign w_other    = bus.req & ~w_srv_mask;
    assign w_cnt_inc  = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // State, counter, pointer and lamp registers; reset forces all-red immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_ALL_RED;
            r_cnt       <= '0;
            r_last      <= C_LAST_RST;
            r_srv       <= '0;
            r_green     <= '0;
            r_yellow    <= '0;
            r_red       <= '1;
            r_active_id <= C_ID_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            r_srv       <= w_srv_nxt;
            r_green     <= w_green_nxt;
            r_yellow    <= w_yellow_nxt;
            r_red       <= w_red_nxt;
            r_active_id <= w_active_id_nxt;
        end
    end

    // Next-state: nothing moves except on a tick edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_srv_nxt   = r_srv;
        if (bus.tick) begin
            w_cnt_nxt = w_cnt_inc;
            case (r_state)
                S_ALL_RED: begin
                    if (r_cnt >= C_ALLRED_END) begin
                        if (bus.req != '0) begin
                            w_state_nxt = S_GREEN;
                            w_srv_nxt   = w_grant;
                            w_cnt_nxt   = '0;
                        end else begin
                            // Park at the expiry value so the next request exits at once.
                            w_cnt_nxt = C_ALLRED_END;
                        end
                    end
                end
                S_GREEN: begin
                    if ((w_other != '0) &&
                        (((r_cnt >= C_GMIN_END) && !bus.req[r_srv]) ||
                         (r_cnt >= C_GMAX_END))) begin
                        w_state_nxt = S_YELLOW;
                        w_cnt_nxt   = '0;
                    end
                end
                S_YELLOW: begin
                    if (r_cnt >= C_YEL_END) begin
                        w_state_nxt = S_ALL_RED;
                        w_last_nxt  = r_srv;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_ALL_RED;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Lamp decode from the next state so registered lamps line up with the state.
    always_comb begin
        w_nxt_mask      = N_APP'(1) << w_srv_nxt;
        w_green_nxt     = '0;
        w_yellow_nxt    = '0;
        w_red_nxt       = '1;
        w_active_id_nxt = C_ID_NONE;
        case (w_state_nxt)
            S_GREEN: begin
                w_green_nxt     = w_nxt_mask;
                w_red_nxt       = ~w_nxt_mask;
                w_active_id_nxt = w_srv_nxt;
            end
            S_YELLOW: begin
                w_yellow_nxt    = w_nxt_mask;
                w_red_nxt       = ~w_nxt_mask;
                w_active_id_nxt = w_srv_nxt;
            end
            default: begin
                w_red_nxt       = '1;
            end
        endcase
    end

    assign bus.green     = r_green;
    assign bus.yellow    = r_yellow;
    assign bus.red       = r_red;
    assign bus.active_id = r_active_id;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed scoreboard bench for traffic_phase_arbiter at default timing parameters.
module tb_traffic_phase_arbiter;

    typedef struct packed {
        logic [2:0] g;
        logic [2:0] y;
        logic [2:0] r;
        logic [1:0] id;
    } lamps_t;

    logic   clk;
    logic   rst_n;
    int     n_pass;
    int     n_total;
    lamps_t exp_q[$];
    string  tag_q[$];

    traffic_phase_arbiter_if bus ();

    traffic_phase_arbiter #(
        .GREEN_MIN (4),
        .GREEN_MAX (10),
        .YELLOW_T  (2),
        .ALLRED_T  (1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic lamps_t lamp_green(input int a);
        lamps_t e;
        e.g  = 3'(1 << a);
        e.y  = 3'b000;
        e.r  = ~e.g;
        e.id = 2'(a);
        return e;
    endfunction

    function automatic lamps_t lamp_yellow(input int a);
        lamps_t e;
        e.g  = 3'b000;
        e.y  = 3'(1 << a);
        e.r  = ~e.y;
        e.id = 2'(a);
        return e;
    endfunction

    function automatic lamps_t lamp_red();
        lamps_t e;
        e.g  = 3'b000;
        e.y  = 3'b000;
        e.r  = 3'b111;
        e.id = 2'd3;
        return e;
    endfunction

    task automatic push_exp(input lamps_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Pop the oldest expectation and compare it with the live lamps, plus lamp invariants.
    task automatic check_front();
        lamps_t e;
        lamps_t o;
        string  tag;
        logic   ok_inv;
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        o   = {bus.green, bus.yellow, bus.red, bus.active_id};
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s: observed g=%b y=%b r=%b id=%0d, expected g=%b y=%b r=%b id=%0d",
                    tag, o.g, o.y, o.r, o.id, e.g, e.y, e.r, e.id);
        ok_inv = ($countones(bus.green | bus.yellow) <= 1);
        for (int i = 0; i < 3; i++)
            ok_inv = ok_inv && ($countones({bus.green[i], bus.yellow[i], bus.red[i]}) == 1);
        n_total++;
        assert (ok_inv === 1'b1) n_pass++;
        else $error("FAIL %s_invariant: observed g=%b y=%b r=%b, expected one lamp per approach",
                    tag, bus.green, bus.yellow, bus.red);
    endtask

    task automatic drive_tick(input logic [2:0] rq, input lamps_t e, input string tag);
        @(negedge clk);
        bus.req  = rq;
        bus.tick = 1'b1;
        push_exp(e, tag);
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
        check_front();
    endtask

    task automatic idle_clk(input int n, input lamps_t e, input string tag);
        for (int k = 0; k < n; k++) begin
            push_exp(e, tag);
            @(posedge clk);
            #1;
            check_front();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        push_exp(lamp_red(), "reset_assert");
        #1;
        check_front();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int phase;
        int ap;
        lamps_t e;
        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b1;
        bus.tick = 1'b0;
        bus.req  = 3'b000;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        push_exp(lamp_red(), "reset_async");
        #2;
        check_front();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // No tick: stays all-red even with a request present.
        bus.req = 3'b001;
        idle_clk(3, lamp_red(), "no_tick_hold");
        drive_tick(3'b001, lamp_green(0), "first_grant");
        for (int t = 0; t < 50; t++)
            drive_tick(3'b001, lamp_green(0), "green_rest");
        idle_clk(2, lamp_green(0), "green_idle");

        // Max-out with approach 1 waiting.
        do_reset();
        drive_tick(3'b011, lamp_green(0), "maxout_entry");
        for (int t = 1; t <= 9; t++)
            drive_tick(3'b011, lamp_green(0), "maxout_green");
        drive_tick(3'b011, lamp_yellow(0), "maxout_yellow10");
        drive_tick(3'b011, lamp_yellow(0), "maxout_yellow11");
        drive_tick(3'b011, lamp_red(), "maxout_allred");
        drive_tick(3'b011, lamp_green(1), "maxout_next_green");

        // Gap-out after the minimum green.
        do_reset();
        drive_tick(3'b011, lamp_green(0), "gap_entry");
        drive_tick(3'b011, lamp_green(0), "gap_t1");
        drive_tick(3'b010, lamp_green(0), "gap_t2");
        drive_tick(3'b010, lamp_green(0), "gap_t3");
        drive_tick(3'b010, lamp_yellow(0), "gap_t4_yellow");

        // Full demand: 10 green, 2 yellow, 1 all-red per approach, rotating 0,1,2.
        do_reset();
        for (int t = 0; t < 102; t++) begin
            phase = t % 13;
            ap    = (t / 13) % 3;
            if (phase < 10)      e = lamp_green(ap);
            else if (phase < 12) e = lamp_yellow(ap);
            else                 e = lamp_red();
            drive_tick(3'b111, e, "rotate");
        end

        // Short reset pulse mid-yellow acts without a clock edge.
        @(negedge clk);
        #1 rst_n = 1'b0;
        push_exp(lamp_red(), "reset_mid_yellow");
        #1;
        check_front();
        #1 rst_n = 1'b1;
        bus.req = 3'b101;
        idle_clk(1, lamp_red(), "post_reset_idle");
        drive_tick(3'b101, lamp_green(0), "post_reset_grant");

        // Tick held high across three edges counts as three ticks.
        for (int t = 1; t <= 8; t++)
            drive_tick(3'b101, lamp_green(0), "hold_pre");
        @(negedge clk);
        bus.tick = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_exp((k == 0) ? lamp_green(0) : lamp_yellow(0), "tick_held");
            @(posedge clk);
            #1;
            check_front();
        end
        bus.tick = 1'b0;
        drive_tick(3'b101, lamp_red(), "hold_allred");
        drive_tick(3'b101, lamp_green(2), "hold_next_grant");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
